// File: rtl/alu_mul_pkg.sv
// ---------------------------------------------------------------------------
// alu_mul_pkg
//   Shared definitions for the iterative multiplier: default operand width,
//   RV32M multiply op codes, FSM state encoding and operand-signedness helpers.
// ---------------------------------------------------------------------------
package alu_mul_pkg;

  localparam int MUL_XLEN = 32;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,  // low half, sign-agnostic
    MUL_OP_MULH   = 2'b01,  // high half, signed x signed
    MUL_OP_MULHSU = 2'b10,  // high half, signed x unsigned
    MUL_OP_MULHU  = 2'b11   // high half, unsigned x unsigned
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mul_state_e;

  // The low half of a product is the same whatever the signedness, so MUL
  // is treated as unsigned to keep the magnitude path trivial.
  function automatic logic op_a_signed(input mul_op_e op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic op_b_signed(input mul_op_e op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/alu_mul_fix.sv
// ---------------------------------------------------------------------------
// alu_mul_fix
//   Combinational sign fix-up for the multiplier: conditionally negates the
//   2*XLEN magnitude product and selects the half requested by the op.
// Ports
//   i_prod    in  2*XLEN  unsigned magnitude product
//   i_neg     in  1       apply two's-complement negation
//   i_op      in  2       op code (MUL selects low half, others high half)
//   o_result  out XLEN    selected half of the signed product
// ---------------------------------------------------------------------------
module alu_mul_fix
  import alu_mul_pkg::*;
#(
  parameter int XLEN = MUL_XLEN
) (
  input  logic [2*XLEN-1:0] i_prod,
  input  logic              i_neg,
  input  mul_op_e           i_op,
  output logic [XLEN-1:0]   o_result
);

  logic [2*XLEN-1:0] w_p;

  always_comb begin
    // NOTE: every variable assigned here gets a value on every path, so no
    // latch can be inferred; keep it that way when editing.
    w_p      = i_neg ? -i_prod : i_prod;
    o_result = (i_op == MUL_OP_MUL) ? w_p[XLEN-1:0] : w_p[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/alu_mul.sv
// ---------------------------------------------------------------------------
// alu_mul
//   Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
//   Operands are reduced to unsigned magnitudes at launch, one multiplier bit
//   is consumed per clock, and the sign is applied once in the FIX state.
//   Flow: IDLE -> CALC (XLEN cycles) -> FIX -> DONE (IDLE with READY=1).
// Ports
//   clk     in  1     rising-edge clock
//   rst     in  1     synchronous active-high reset
//   start   in  1     launch request, honoured only in IDLE/DONE
//   op      in  2     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   src_A   in  XLEN  multiplicand
//   src_B   in  XLEN  multiplier
//   result  out XLEN  selected product half, held until the next FIX
//   busy    out 1     operation in flight
//   READY   out 1     result valid and nothing in flight
// Configuration
//   ALU_MUL_EARLY_OUT_EN: when defined, CALC exits to FIX as soon as the
//   remaining multiplier is zero. Results are identical either way.
// ---------------------------------------------------------------------------
module alu_mul
  import alu_mul_pkg::*;
#(
  parameter int XLEN = MUL_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_A,
  input  logic [XLEN-1:0] src_B,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            READY
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  mul_state_e          r_state;
  mul_op_e             r_op;
  logic [XLEN-1:0]     r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic [2*XLEN-1:0]   r_prod;
  logic [CNT_W-1:0]    r_count;
  logic                r_neg;

  mul_op_e             w_op_in;
  logic                w_sgn_a;
  logic                w_sgn_b;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic [2*XLEN-1:0]   w_partial;
  logic                w_early_out;
  logic [XLEN-1:0]     w_fix_result;

  // Launch-time operand conditioning. Negating the most negative value
  // wraps to itself, which is exactly its unsigned magnitude.
  assign w_op_in = mul_op_e'(op);
  assign w_sgn_a = src_A[XLEN-1] & op_a_signed(w_op_in);
  assign w_sgn_b = src_B[XLEN-1] & op_b_signed(w_op_in);
  assign w_mag_a = w_sgn_a ? -src_A : src_A;
  assign w_mag_b = w_sgn_b ? -src_B : src_B;

  assign w_partial = {{XLEN{1'b0}}, r_mcand} << r_count;

`ifdef ALU_MUL_EARLY_OUT_EN
  // Once all multiplier bits are consumed the product cannot change.
  assign w_early_out = (r_mplier == '0);
`else
  assign w_early_out = 1'b0;
`endif

  alu_mul_fix #(.XLEN(XLEN)) u_fix (
    .i_prod   (r_prod),
    .i_neg    (r_neg),
    .i_op     (r_op),
    .o_result (w_fix_result)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= MUL_OP_MUL;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      READY    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_op     <= w_op_in;
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= w_sgn_a ^ w_sgn_b;
            r_prod   <= '0;
            r_count  <= '0;
            READY    <= 1'b0;
            busy     <= 1'b1;
            r_state  <= ST_CALC;
          end
        end

        ST_CALC: begin
          if (w_early_out) begin
            r_state <= ST_FIX;
          end else begin
            if (r_mplier[0]) r_prod <= r_prod + w_partial;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CNT_W'(1);
            if (r_count == CNT_W'(XLEN - 1)) r_state <= ST_FIX;
          end
        end

        ST_FIX: begin
          result  <= w_fix_result;
          READY   <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_DONE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
